// File: rtl/regfile_ff.sv
// 32 x 64 general-purpose register file built from single-bit D_FF flops, X31 hardwired to zero.
// Optional write-to-read bypass on both read ports: define REGFILE_BYPASS_EN.
module regfile_ff #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  if (ADDR_W != $clog2(NUM_REGS)) begin : g_bad_cfg
    $error("regfile_ff: ADDR_W must equal log2(NUM_REGS)");
  end

  // Row NUM_REGS-1 (XZR) is a constant zero row so the read muxes need no special case.
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             en;

  for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_row
    assign en[r] = RegWrite & (WriteRegister == ADDR_W'(r));
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      D_FF u_ff (
        .clk   (clk),
        .reset (reset),
        .d     (en[r] ? WriteData[b] : regs[r][b]),
        .q     (regs[r][b])
      );
    end
  end

  assign en[NUM_REGS-1]   = 1'b0;
  assign regs[NUM_REGS-1] = '0;

`ifdef REGFILE_BYPASS_EN
  // en[] is already zero for XZR, so the bypass can never make X31 read non-zero.
  assign ReadData1 = en[ReadRegister1] ? WriteData : regs[ReadRegister1];
  assign ReadData2 = en[ReadRegister2] ? WriteData : regs[ReadRegister2];
`else
  assign ReadData1 = regs[ReadRegister1];
  assign ReadData2 = regs[ReadRegister2];
`endif

endmodule

// Single-bit storage flop with synchronous active-high clear.
module D_FF (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values in the same delta.
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: tb/tb_regfile_ff.sv
// Self-checking bench for regfile_ff: directed scenarios plus randomized traffic against an array model.
module tb_regfile_ff;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model [NUM_REGS];

  regfile_ff #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Architectural value of a register as seen after all committed edges.
  function automatic logic [DATA_W-1:0] arch_val(input int a);
    return (a == NUM_REGS - 1) ? '0 : model[a];
  endfunction

  // What a read port must show before the edge, given the pending write.
  function automatic logic [DATA_W-1:0] pre_edge_val(input int a, input logic we,
                                                     input int wa, input logic [DATA_W-1:0] wd);
    if (BYPASS && we && wa == a && a != NUM_REGS - 1) return wd;
    return arch_val(a);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = ADDR_W'(a);
    WriteData     = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    if (a != NUM_REGS - 1) model[a] = d;
  endtask

  task automatic read_pair(input int a, input int b,
                           output logic [DATA_W-1:0] d1, output logic [DATA_W-1:0] d2);
    ReadRegister1 = ADDR_W'(a);
    ReadRegister2 = ADDR_W'(b);
    #1;
    d1 = ReadData1;
    d2 = ReadData2;
  endtask

  task automatic pulse_reset(input logic we, input int a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    reset         = 1'b1;
    RegWrite      = we;
    WriteRegister = ADDR_W'(a);
    WriteData     = d;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    RegWrite = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d1, d2;
    reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < NUM_REGS; i++) begin
      read_pair(i, NUM_REGS - 1 - i, d1, d2);
      checks++;
      if (d1 !== '0 || d2 !== '0) begin
        failures++;
        $display("FAIL reset_state idx=%0d rd1=%h rd2=%h expected 0", i, d1, d2);
      end
    end
    do_write(5, 64'hDEAD_BEEF);
    pulse_reset(1'b1, 6, 64'h1234);
    read_pair(5, 6, d1, d2);
    checks++;
    if (d1 !== '0 || d2 !== '0) begin
      failures++;
      $display("FAIL reset_clear x5=%h x6=%h expected 0 0", d1, d2);
    end
  endtask

  task automatic test_sweep();
    logic [DATA_W-1:0] d1, d2;
    for (int i = 0; i < NUM_REGS - 1; i++) do_write(i, DATA_W'(i) * 64'h0101_0101_0101_0101);
    for (int i = 0; i < NUM_REGS; i++) begin
      read_pair(i, i, d1, d2);
      checks++;
      if (d1 !== arch_val(i) || d2 !== arch_val(i) ||
          (i < NUM_REGS - 1 && d1 !== DATA_W'(i) * 64'h0101_0101_0101_0101)) begin
        failures++;
        $display("FAIL sweep idx=%0d rd1=%h rd2=%h expected %h", i, d1, d2, arch_val(i));
      end
    end
  endtask

  task automatic test_xzr();
    logic [DATA_W-1:0] d1, d2;
    do_write(NUM_REGS - 1, '1);
    read_pair(NUM_REGS - 1, NUM_REGS - 1, d1, d2);
    checks++;
    if (d1 !== '0 || d2 !== '0) begin
      failures++;
      $display("FAIL xzr_read rd1=%h rd2=%h expected 0", d1, d2);
    end
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      read_pair(i, i, d1, d2);
      checks++;
      if (d1 !== model[i] || d2 !== model[i]) begin
        failures++;
        $display("FAIL xzr_others idx=%0d rd1=%h rd2=%h expected %h", i, d1, d2, model[i]);
      end
    end
  endtask

  task automatic test_write_gating();
    logic [DATA_W-1:0] d1, d2;
    do_write(3, 64'h55);
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd3;
    WriteData     = 64'hAAAA;
    @(posedge clk);
    #1;
    @(negedge clk);
    WriteRegister = 'x;
    WriteData     = 'x;
    @(posedge clk);
    #1;
    read_pair(3, 3, d1, d2);
    checks++;
    if (d1 !== 64'h55 || d2 !== 64'h55) begin
      failures++;
      $display("FAIL we_gating x3 rd1=%h rd2=%h expected 55", d1, d2);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      read_pair(i, i, d1, d2);
      checks++;
      if (d1 !== arch_val(i) || d2 !== arch_val(i)) begin
        failures++;
        $display("FAIL we_gating_all idx=%0d rd1=%h expected %h", i, d1, arch_val(i));
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [DATA_W-1:0] d1, d2, pre;
    do_write(7, 64'h10);
    pre = BYPASS ? 64'h20 : 64'h10;
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'h20;
    read_pair(7, 8, d1, d2);
    checks++;
    if (d1 !== pre || d2 !== arch_val(8)) begin
      failures++;
      $display("FAIL same_cycle_pre x7=%h x8=%h expected %h %h", d1, d2, pre, arch_val(8));
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    model[7] = 64'h20;
    read_pair(7, 7, d1, d2);
    checks++;
    if (d1 !== 64'h20 || d2 !== 64'h20) begin
      failures++;
      $display("FAIL same_cycle_post rd1=%h rd2=%h expected 20", d1, d2);
    end
    // A pending write to X31 must never leak onto a read of X31.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = '1;
    read_pair(31, 31, d1, d2);
    checks++;
    if (d1 !== '0 || d2 !== '0) begin
      failures++;
      $display("FAIL same_cycle_xzr rd1=%h rd2=%h expected 0", d1, d2);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic test_dual_port();
    logic [DATA_W-1:0] d1, d2;
    do_write(12, 64'hCAFE);
    read_pair(12, 12, d1, d2);
    checks++;
    if (d1 !== 64'hCAFE || d2 !== 64'hCAFE) begin
      failures++;
      $display("FAIL dual_port rd1=%h rd2=%h expected cafe", d1, d2);
    end
  endtask

  task automatic test_reset_midprogram();
    logic [DATA_W-1:0] d1, d2;
    pulse_reset(1'b0, 0, '0);
    do_write(9, 64'h0123_4567_89AB_CDEF);
    read_pair(9, 12, d1, d2);
    checks++;
    if (d1 !== 64'h0123_4567_89AB_CDEF || d2 !== '0) begin
      failures++;
      $display("FAIL reset_then_write x9=%h x12=%h expected 0123456789abcdef 0", d1, d2);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d1, d2, wd;
    logic              we;
    int                wa, a1, a2;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = int'($urandom_range(0, NUM_REGS - 1));
      wd = {$urandom(), $urandom()};
      a1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NUM_REGS - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NUM_REGS - 1));
      @(negedge clk);
      RegWrite      = we;
      WriteRegister = ADDR_W'(wa);
      WriteData     = wd;
      read_pair(a1, a2, d1, d2);
      checks++;
      if (d1 !== pre_edge_val(a1, we, wa, wd) || d2 !== pre_edge_val(a2, we, wa, wd)) begin
        failures++;
        $display("FAIL random n=%0d a1=%0d rd1=%h exp %h a2=%0d rd2=%h exp %h", n, a1, d1,
                 pre_edge_val(a1, we, wa, wd), a2, d2, pre_edge_val(a2, we, wa, wd));
      end
      @(posedge clk);
      #1;
      if (we && wa != NUM_REGS - 1) model[wa] = wd;
    end
    RegWrite = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      read_pair(i, NUM_REGS - 1 - i, d1, d2);
      checks++;
      if (d1 !== arch_val(i) || d2 !== arch_val(NUM_REGS - 1 - i)) begin
        failures++;
        $display("FAIL random_final idx=%0d rd1=%h exp %h", i, d1, arch_val(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_xzr();
    test_write_gating();
    test_same_cycle();
    test_dual_port();
    test_reset_midprogram();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
